int32_to_fp32_pipe: RTL

Three-stage pipelined converter from a 32-bit integer to an IEEE-754 single-precision float. It is the inverse of the fp32 library's float-to-int32 path, which is combinational and truncating. The block sits on a valid/ready stream between an integer producer and fp32 datapath consumers. It accepts one operand per cycle, supports full backpressure, and reports inexact results.

---
 rtl/int32_to_fp32_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/int32_to_fp32_pipe.sv
// rtl/int32_to_fp32_pipe.sv - three-stage int32 to fp32 converter on a valid/ready stream
// Rounding: round-to-nearest-even when INT32_TO_FP32_RNE_EN is defined, truncation otherwise.
module int32_to_fp32_pipe #(
  parameter int SIGNED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_out,
  output logic        out_inexact
);

  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  // Each stage may load when it is empty or its contents move on this cycle.
  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign adv1      = !v1 || adv2;
  assign in_ready  = rst_n && adv1;
  assign out_valid = v3;

  // S1: sign/magnitude
  logic        s1_sign_d;
  logic [31:0] s1_mag_d;
  logic        s1_sign, s1_zero;
  logic [31:0] s1_mag;

  assign s1_sign_d = (SIGNED != 0) ? int_in[31] : 1'b0;
  assign s1_mag_d  = s1_sign_d ? (~int_in + 32'd1) : int_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= 32'd0;
      s1_zero <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign <= s1_sign_d;
        s1_mag  <= s1_mag_d;
        s1_zero <= (int_in == 32'd0);
      end
    end
  end

  // S2: normalise so the leading one lands in bit 31
  logic [4:0]  lz;
  logic [31:0] norm_d;
  logic [7:0]  exp_d;
  logic        s2_sign, s2_zero;
  logic [31:0] s2_norm;
  logic [7:0]  s2_exp;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag[i]) lz = 5'(31 - i);
    end
  end

  assign norm_d = s1_mag << lz;
  assign exp_d  = 8'd158 - {3'b000, lz};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_norm <= 32'd0;
      s2_exp  <= 8'd0;
      s2_zero <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign <= s1_sign;
        s2_norm <= norm_d;
        s2_exp  <= exp_d;
        s2_zero <= s1_zero;
      end
    end
  end

  // S3: round and pack
  logic [22:0] mant;
  logic        guard_bit, sticky_bit, round_up;
  logic [23:0] mant_sum;
  logic [7:0]  exp_r;
  logic [31:0] fp_d;
  logic        inexact_d;

  assign mant       = s2_norm[30:8];
  assign guard_bit  = s2_norm[7];
  assign sticky_bit = |s2_norm[6:0];
`ifdef INT32_TO_FP32_RNE_EN
  assign round_up   = guard_bit && (sticky_bit || mant[0]);
`else
  assign round_up   = 1'b0;
`endif
  // A mantissa carry leaves mant_sum[22:0] at zero, so only the exponent needs bumping.
  assign mant_sum   = {1'b0, mant} + {23'd0, round_up};
  assign exp_r      = s2_exp + {7'd0, mant_sum[23]};
  assign fp_d       = s2_zero ? 32'd0 : {s2_sign, exp_r, mant_sum[22:0]};
  assign inexact_d  = !s2_zero && (guard_bit || sticky_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3          <= 1'b0;
      fp_out      <= 32'd0;
      out_inexact <= 1'b0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        fp_out      <= fp_d;
        out_inexact <= inexact_d;
      end
    end
  end

endmodule
